// File: rtl/lblock_axi4_burst_slave.sv
// AXI4 burst slave holding the LBlock plaintext, key and control words.
// Independent write and read FSMs share one DEPTH-word register array.
//
// state  | meaning
// W_IDLE | waiting for a write address
// W_DATA | accepting write beats
// W_RESP | presenting the write response until BREADY
// R_IDLE | waiting for a read address
// R_DATA | presenting read beats until the RLAST handshake
module lblock_axi4_burst_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int DEPTH              = 16
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]         S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [7:0]                          S_AXI_AWLEN,
    input  logic [2:0]                          S_AXI_AWSIZE,
    input  logic [1:0]                          S_AXI_AWBURST,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WLAST,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]         S_AXI_BID,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]         S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [7:0]                          S_AXI_ARLEN,
    input  logic [2:0]                          S_AXI_ARSIZE,
    input  logic [1:0]                          S_AXI_ARBURST,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]         S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RLAST,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*DEPTH-1:0] regs_flat,
    output logic                                wr_pulse
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic     ready_en;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

    logic [C_S_AXI_ID_WIDTH-1:0]   w_id, r_id;
    logic [IDX_W-1:0]              w_idx, r_idx, ar_idx;
    logic [7:0]                    w_rem, r_rem;
    logic                          w_fixed, w_bad, w_err;
    logic                          r_fixed, r_bad, r_last;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_data;
    logic                          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                          unused_addr_bits;

    function automatic logic bad_burst(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd2) || burst[1];
    endfunction

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign b_hs   = S_AXI_BVALID && S_AXI_BREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs   = S_AXI_RVALID && S_AXI_RREADY;
    assign ar_idx = S_AXI_ARADDR[IDX_W+1:2];
    assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_BID   = w_id;
    assign S_AXI_BRESP = S_AXI_BVALID ? {w_err, 1'b0} : 2'b00;
    assign S_AXI_RID   = r_id;
    assign S_AXI_RDATA = r_data;
    assign S_AXI_RLAST = r_last;
    assign S_AXI_RRESP = S_AXI_RVALID ? {r_bad, 1'b0} : 2'b00;

    // ready_en keeps both address channels closed for the first cycle out of reset
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            ready_en <= 1'b0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        w_next        = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = ready_en;
                if (S_AXI_AWVALID && ready_en) w_next = W_DATA;
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_rem == 8'd0) w_next = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next        = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = ready_en;
                if (S_AXI_ARVALID && ready_en) r_next = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Burst ends on the beat count; a WLAST disagreement only poisons the response
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_id     <= '0;
            w_idx    <= '0;
            w_rem    <= '0;
            w_fixed  <= 1'b0;
            w_bad    <= 1'b0;
            w_err    <= 1'b0;
            wr_pulse <= 1'b0;
        end else begin
            wr_pulse <= b_hs;
            if (aw_hs) begin
                w_id    <= S_AXI_AWID;
                w_idx   <= S_AXI_AWADDR[IDX_W+1:2];
                w_rem   <= S_AXI_AWLEN;
                w_fixed <= (S_AXI_AWBURST == 2'd0);
                w_bad   <= bad_burst(S_AXI_AWSIZE, S_AXI_AWBURST);
                w_err   <= bad_burst(S_AXI_AWSIZE, S_AXI_AWBURST);
            end else if (w_hs) begin
                w_rem <= w_rem - 8'd1;
                if (!w_fixed) w_idx <= w_idx + IDX_W'(1);
                if (S_AXI_WLAST != (w_rem == 8'd0)) w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (w_hs && !w_bad) begin
            for (int b = 0; b < STRB_W; b++)
                if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) regs_flat <= '0;
        else for (int i = 0; i < DEPTH; i++) regs_flat[C_S_AXI_DATA_WIDTH*i +: C_S_AXI_DATA_WIDTH] <= mem[i];
    end

    // Next beat is fetched on the handshake edge, so a same-cycle write is not seen
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_id    <= '0;
            r_idx   <= '0;
            r_rem   <= '0;
            r_fixed <= 1'b0;
            r_bad   <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (ar_hs) begin
            r_id    <= S_AXI_ARID;
            r_rem   <= S_AXI_ARLEN;
            r_fixed <= (S_AXI_ARBURST == 2'd0);
            r_bad   <= bad_burst(S_AXI_ARSIZE, S_AXI_ARBURST);
            r_last  <= (S_AXI_ARLEN == 8'd0);
            r_data  <= bad_burst(S_AXI_ARSIZE, S_AXI_ARBURST) ? '0 : mem[ar_idx];
            r_idx   <= (S_AXI_ARBURST == 2'd0) ? ar_idx : ar_idx + IDX_W'(1);
        end else if (r_hs) begin
            if (r_last) begin
                r_last <= 1'b0;
            end else begin
                r_data <= r_bad ? '0 : mem[r_idx];
                r_rem  <= r_rem - 8'd1;
                r_last <= (r_rem == 8'd1);
                if (!r_fixed) r_idx <= r_idx + IDX_W'(1);
            end
        end
    end
endmodule
